// File: rtl/bus_arbit_rr.sv
// ---------------------------------------------------------------------------
// bus_arbit_rr
//
// Fair two-master arbiter for the shared 2-master / 5-slave system bus.
// Exactly one master owns the bus at any time. Ownership changes either
// voluntarily (the owner drops its request while the other master requests)
// or by force, once the owner has held the bus for MAX_HOLD consecutive
// contended cycles. With no requests the grant stays parked on the last
// owner. Per-master saturating counters record how many times each master
// has been handed the bus.
//
// Parameters
//   MAX_HOLD : contended cycles an owner may keep the bus (0 = never preempt)
//   HOLD_W   : width of the hold counter (MAX_HOLD <= 2**HOLD_W - 1)
//   CNT_W    : width of the per-master grant statistic counters
//
// Ports
//   clk         in   system clock, rising-edge
//   reset_n     in   asynchronous active-low reset
//   M0_req      in   master 0 request (level, held while transferring)
//   M1_req      in   master 1 request (level, held while transferring)
//   M0_grant    out  master 0 owns the bus (decoded from the state flop)
//   M1_grant    out  master 1 owns the bus; also the bus mux select
//   handover    out  pulse in the first cycle a new grant is visible
//   preempt     out  pulse alongside handover when the switch was forced
//   M0_gnt_cnt  out  handovers to master 0, saturating
//   M1_gnt_cnt  out  handovers to master 1, saturating
// ---------------------------------------------------------------------------
module bus_arbit_rr #(
  parameter int MAX_HOLD = 4,
  parameter int HOLD_W   = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             M0_req,
  input  logic             M1_req,
  output logic             M0_grant,
  output logic             M1_grant,
  output logic             handover,
  output logic             preempt,
  output logic [CNT_W-1:0] M0_gnt_cnt,
  output logic [CNT_W-1:0] M1_gnt_cnt
);

  typedef enum logic [0:0] {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } state_e;

  localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  // Counter value at which the next contended edge forces a handover.
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    (MAX_HOLD == 0) ? HOLD_ZERO : HOLD_W'(MAX_HOLD - 1);
  localparam logic HOLD_EN = (MAX_HOLD != 0) ? 1'b1 : 1'b0;

  // Saturating increment for the grant statistics: sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

  state_e            state_q,    state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              handover_q, handover_d;
  logic              preempt_q,  preempt_d;
  logic [CNT_W-1:0]  m0_cnt_q,   m0_cnt_d;
  logic [CNT_W-1:0]  m1_cnt_q,   m1_cnt_d;

  logic owner_req_s;
  logic other_req_s;
  logic at_limit_s;
  logic switch_s;
  logic forced_s;

  // Re-express the requests relative to the current owner.
  always_comb begin
    owner_req_s = 1'b0;
    other_req_s = 1'b0;
    if (state_q == OWN_M1) begin
      owner_req_s = M1_req;
      other_req_s = M0_req;
    end else begin
      owner_req_s = M0_req;
      other_req_s = M1_req;
    end
  end

  // Arbitration decision: switch or stay, and how the hold counter moves.
  always_comb begin
    switch_s   = 1'b0;
    forced_s   = 1'b0;
    hold_cnt_d = HOLD_ZERO;
    at_limit_s = HOLD_EN & (hold_cnt_q == HOLD_LAST);
    if (other_req_s) begin
      if (!owner_req_s) begin
        // Owner let go. If this happens exactly when the hold limit would
        // have fired anyway (a real contended streak reached the limit),
        // report it as a forced handover since the outcome is identical.
        switch_s = 1'b1;
        forced_s = at_limit_s & (hold_cnt_q != HOLD_ZERO);
      end else if (at_limit_s) begin
        switch_s = 1'b1;
        forced_s = 1'b1;
      end else begin
        // Contended but still within the hold budget.
        if (HOLD_EN) begin
          hold_cnt_d = hold_cnt_q + HOLD_ONE;
        end else begin
          hold_cnt_d = HOLD_ZERO;
        end
      end
    end else begin
      // Nobody is waiting: the streak of contended cycles is broken.
      hold_cnt_d = HOLD_ZERO;
    end
  end

  // Next owner, event pulses and statistic updates.
  always_comb begin
    state_d    = state_q;
    m0_cnt_d   = m0_cnt_q;
    m1_cnt_d   = m1_cnt_q;
    handover_d = switch_s;
    preempt_d  = switch_s & forced_s;
    if (switch_s) begin
      case (state_q)
        OWN_M0: begin
          state_d  = OWN_M1;
          m1_cnt_d = sat_inc(m1_cnt_q);
        end
        OWN_M1: begin
          state_d  = OWN_M0;
          m0_cnt_d = sat_inc(m0_cnt_q);
        end
        default: begin
          state_d = OWN_M0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and statistics registers; reset parks the bus on master 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= OWN_M0;
      hold_cnt_q <= HOLD_ZERO;
      handover_q <= 1'b0;
      preempt_q  <= 1'b0;
      m0_cnt_q   <= {CNT_W{1'b0}};
      m1_cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      handover_q <= handover_d;
      preempt_q  <= preempt_d;
      m0_cnt_q   <= m0_cnt_d;
      m1_cnt_q   <= m1_cnt_d;
    end
  end

  // Grants decode straight from the state flop, so req never reaches
  // grant combinationally and exactly one grant is high by construction.
  assign M0_grant   = (state_q == OWN_M0);
  assign M1_grant   = (state_q == OWN_M1);
  assign handover   = handover_q;
  assign preempt    = preempt_q;
  assign M0_gnt_cnt = m0_cnt_q;
  assign M1_gnt_cnt = m1_cnt_q;

endmodule

// File: tb/tb_bus_arbit_rr.sv
module tb_bus_arbit_rr;

  localparam int MAX_HOLD = 4;
  localparam int CNT_MAX  = 255;

  logic clk;
  logic reset_n;

  // Default build (MAX_HOLD=4, CNT_W=8)
  logic       m0_req, m1_req;
  logic       m0_grant, m1_grant, ho, pre;
  logic [7:0] c0, c1;

  // MAX_HOLD=0 build
  logic       h_m0_req, h_m1_req;
  logic       h_m0_grant, h_m1_grant, h_ho, h_pre;
  logic [7:0] h_c0, h_c1;

  // CNT_W=2 build
  logic       s_m0_req, s_m1_req;
  logic       s_m0_grant, s_m1_grant, s_ho, s_pre;
  logic [1:0] s_c0, s_c1;

  int n_checks = 0;
  int n_fail   = 0;

  bus_arbit_rr #(.MAX_HOLD(4), .HOLD_W(4), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .M0_req(m0_req), .M1_req(m1_req),
    .M0_grant(m0_grant), .M1_grant(m1_grant), .handover(ho), .preempt(pre),
    .M0_gnt_cnt(c0), .M1_gnt_cnt(c1));

  bus_arbit_rr #(.MAX_HOLD(0), .HOLD_W(4), .CNT_W(8)) dut_nohold (
    .clk(clk), .reset_n(reset_n), .M0_req(h_m0_req), .M1_req(h_m1_req),
    .M0_grant(h_m0_grant), .M1_grant(h_m1_grant), .handover(h_ho), .preempt(h_pre),
    .M0_gnt_cnt(h_c0), .M1_gnt_cnt(h_c1));

  bus_arbit_rr #(.MAX_HOLD(4), .HOLD_W(4), .CNT_W(2)) dut_sat (
    .clk(clk), .reset_n(reset_n), .M0_req(s_m0_req), .M1_req(s_m1_req),
    .M0_grant(s_m0_grant), .M1_grant(s_m1_grant), .handover(s_ho), .preempt(s_pre),
    .M0_gnt_cnt(s_c0), .M1_gnt_cnt(s_c1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic r0;
    logic r1;
    logic exp_m0;
    logic exp_ho;
    logic exp_pre;
    int   exp_c0;
    int   exp_c1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r0, input logic r1, input logic em0,
                              input logic eho, input logic epre,
                              input int ec0, input int ec1);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.exp_m0 = em0; v.exp_ho = eho; v.exp_pre = epre;
    v.exp_c0 = ec0; v.exp_c1 = ec1;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model state: owner index, length of the current contended
  // streak, and handover counts per master.
  int m_owner;
  int m_streak;
  int m_cnt[2];
  bit m_ho;
  bit m_pre;

  task automatic model_reset();
    m_owner = 0; m_streak = 0; m_cnt[0] = 0; m_cnt[1] = 0; m_ho = 0; m_pre = 0;
  endtask

  task automatic model_edge(input bit r0, input bit r1);
    bit r[2];
    int other;
    r[0] = r0; r[1] = r1;
    other = 1 - m_owner;
    m_ho = 0; m_pre = 0;
    if (!r[other]) begin
      m_streak = 0;
    end else if (!r[m_owner]) begin
      m_ho  = 1;
      m_pre = (m_streak == MAX_HOLD - 1) && (m_streak > 0);
    end else if (m_streak + 1 == MAX_HOLD) begin
      m_ho = 1; m_pre = 1;
    end else begin
      m_streak++;
    end
    if (m_ho) begin
      m_owner = other;
      m_streak = 0;
      if (m_cnt[m_owner] < CNT_MAX) m_cnt[m_owner]++;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    m0_req = 1'b1; m1_req = 1'b1;
    h_m0_req = 1'b0; h_m1_req = 1'b0;
    s_m0_req = 1'b0; s_m1_req = 1'b0;

    // ---- reset held 3 cycles with both requests high ----
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m0_grant", m0_grant, 1);
    chk("rst_m1_grant", m1_grant, 0);
    chk("rst_handover", ho, 0);
    chk("rst_preempt", pre, 0);
    chk("rst_c0", c0, 0);
    chk("rst_c1", c1, 0);
    m0_req = 1'b0; m1_req = 1'b0;
    reset_n = 1'b1;

    // ---- directed vector table ----
    //                r0 r1 m0 ho pre c0 c1
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0)); // parked on M0
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 1)); // voluntary to M1
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1)); // park on M1
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 1, 1, 0, 1, 1)); // voluntary to M0
    vecs.push_back(mk(1, 1, 1, 0, 0, 1, 1)); // contended 1
    vecs.push_back(mk(1, 1, 1, 0, 0, 1, 1)); // contended 2
    vecs.push_back(mk(1, 1, 1, 0, 0, 1, 1)); // contended 3
    vecs.push_back(mk(1, 1, 0, 1, 1, 1, 2)); // contended 4 -> forced
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 2));
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 2));
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 2));
    vecs.push_back(mk(1, 1, 1, 1, 1, 2, 2)); // forced back to M0
    vecs.push_back(mk(1, 1, 1, 0, 0, 2, 2)); // contended 1
    vecs.push_back(mk(1, 1, 1, 0, 0, 2, 2)); // contended 2
    vecs.push_back(mk(1, 0, 1, 0, 0, 2, 2)); // break: streak clears
    vecs.push_back(mk(1, 1, 1, 0, 0, 2, 2));
    vecs.push_back(mk(1, 1, 1, 0, 0, 2, 2));
    vecs.push_back(mk(1, 1, 1, 0, 0, 2, 2));
    vecs.push_back(mk(1, 1, 0, 1, 1, 2, 3)); // 6th contended edge -> forced
    vecs.push_back(mk(0, 1, 0, 0, 0, 2, 3));
    vecs.push_back(mk(1, 0, 1, 1, 0, 3, 3)); // voluntary to M0
    vecs.push_back(mk(1, 1, 1, 0, 0, 3, 3));
    vecs.push_back(mk(1, 1, 1, 0, 0, 3, 3));
    vecs.push_back(mk(1, 1, 1, 0, 0, 3, 3));
    vecs.push_back(mk(0, 1, 0, 1, 1, 3, 4)); // owner drops at limit: forced
    vecs.push_back(mk(0, 0, 0, 0, 0, 3, 4));

    foreach (vecs[i]) begin
      m0_req = vecs[i].r0; m1_req = vecs[i].r1;
      step();
      chk($sformatf("vec%0d_m0_grant", i), m0_grant, vecs[i].exp_m0);
      chk($sformatf("vec%0d_m1_grant", i), m1_grant, !vecs[i].exp_m0);
      chk($sformatf("vec%0d_handover", i), ho, vecs[i].exp_ho);
      chk($sformatf("vec%0d_preempt", i), pre, vecs[i].exp_pre);
      chk($sformatf("vec%0d_c0", i), c0, vecs[i].exp_c0);
      chk($sformatf("vec%0d_c1", i), c1, vecs[i].exp_c1);
    end

    // ---- asynchronous reset while OWN_M1, between clock edges ----
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_m0_grant", m0_grant, 1);
    chk("async_m1_grant", m1_grant, 0);
    chk("async_c1", c1, 0);
    chk("async_handover", ho, 0);
    #2;
    m0_req = 1'b0; m1_req = 1'b0;
    reset_n = 1'b1;
    step();

    // ---- MAX_HOLD=0: contention never switches ----
    h_m0_req = 1'b1; h_m1_req = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      chk($sformatf("nohold_m0_grant_%0d", k), h_m0_grant, 1);
      chk($sformatf("nohold_handover_%0d", k), h_ho, 0);
    end
    h_m0_req = 1'b0;
    step();
    chk("nohold_release_m1_grant", h_m1_grant, 1);
    chk("nohold_release_handover", h_ho, 1);
    chk("nohold_release_preempt", h_pre, 0);
    h_m1_req = 1'b0;

    // ---- CNT_W=2: M1 counter saturates at 3 ----
    for (int k = 0; k < 5; k++) begin
      s_m0_req = 1'b0; s_m1_req = 1'b1;
      step();
      chk($sformatf("sat_m1_grant_%0d", k), s_m1_grant, 1);
      chk($sformatf("sat_c1_%0d", k), s_c1, (k + 1 > 3) ? 3 : k + 1);
      s_m0_req = 1'b1; s_m1_req = 1'b0;
      step();
    end
    chk("sat_c0", s_c0, 3);
    s_m0_req = 1'b0;

    // ---- randomized run against the reference model ----
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    model_reset();
    for (int k = 0; k < 10000; k++) begin
      bit r0, r1;
      r0 = ($urandom_range(0, 3) != 0);
      r1 = ($urandom_range(0, 3) != 0);
      m0_req = r0; m1_req = r1;
      step();
      model_edge(r0, r1);
      chk("rnd_exclusive", int'(m0_grant ^ m1_grant), 1);
      chk("rnd_m1_grant", m1_grant, m_owner);
      chk("rnd_handover", ho, int'(m_ho));
      chk("rnd_preempt", pre, int'(m_pre));
      chk("rnd_c0", c0, m_cnt[0]);
      chk("rnd_c1", c1, m_cnt[1]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
